seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Scan controller for the 8-digit multiplexed seven-segment display.
- Sequences the one-hot digit select across all 8 digits, inserting an anti-ghosting blank interval at the start of each digit slot.
- Decodes the 4-bit hex value of the active digit into an active-low segment pattern.
- Accepts new display contents through a valid/ready handshake and applies them only at frame boundaries, so a frame never shows a mix of old and new data.

Parameters:
- DWELL, 1000, clk_div cycles per digit slot (>= 2).
- BLANK, 50, cycles at the start of each slot with select forced to 0 (1 <= BLANK < DWELL).

Ports:
- clk_div  in  1  scan clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; low freezes scanning and blanks the display
- digit_mask  in  8  per-digit enable; bit i=0 keeps digit i dark
- wr_valid  in  1  new display data offered
- wr_data  in  32  digit i value = wr_data[4i+3:4i]
- wr_dp  in  8  decimal point per digit, 1 = lit
- wr_ready  out  1  pending buffer empty, write can be accepted
- select  out  8  one-hot digit select, active-high, bit i = digit i
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low
- frame_done  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Registered state:
  - idx (3b, digit index)
  - cnt (dwell counter, 0..DWELL-1)
  - active_data/active_dp
  - pend_data/pend_dp
  - pend_flag
- Reset (async, rst_n=0): idx=7, cnt=0, active_data=0, active_dp=0, pend_flag=0. Outputs: select=0, seg=8'hFF, wr_ready=1, frame_done=0.
- Scan order: idx 7,6,5,4,3,2,1,0, then back to 7. The select bit rotates right: 8'b10000000 down to 8'b00000001, then wraps to 8'b10000000.
- Counter update, when en=1, each edge:
  - if cnt==DWELL-1: cnt<=0 and idx<=idx-1 (mod 8);
  - else cnt<=cnt+1.
- When en=0: cnt and idx hold. On re-assertion, scanning resumes at the same idx and cnt.
- select (combinational from state) = en && cnt>=BLANK && digit_mask[idx] ? (1<<idx) : 0.
- seg:
  - When select==0: seg=8'hFF.
  - Otherwise: seg = {~active_dp[idx], hex7(active_data nibble idx)}.
  - hex7 table, active-low {g..a}:
    - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
    - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - A lit dp clears bit 7.
- Frame boundary: en=1 && idx==0 && cnt==DWELL-1. On that cycle frame_done=1, combinational. It is 0 at all other times, including when en=0.
- Handshake:
  - wr_ready = ~pend_flag.
  - Accept on wr_valid && wr_ready: capture into pend_*, and pend_flag<=1.
  - wr_data and wr_dp must be stable while wr_valid=1 and wr_ready=0.
- Commit: at a frame boundary with pend_flag=1, active_*<=pend_*, and pend_flag<=0. The new data is first shown at idx=7 of the next frame.
- Simultaneous events:
  - Accept and boundary in the same cycle (pend_flag=0): the word goes to pend. It commits at the next boundary, not the current one.
  - A boundary with pend_flag=0 changes nothing.
- digit_mask is not synchronised or latched. Changes take effect immediately; the caller holds it quasi-static.
- Reset mid-frame or mid-handshake: all state returns to reset values immediately and any pending word is dropped. Scanning restarts at idx=7 with the blank interval.
- Target size: 150-250 lines of RTL.

Test Plan:
- Bench parameters: DWELL=4, BLANK=1, en=1, digit_mask=8'hFF.
- Reset release, no writes:
  - Per slot: select=0 for 1 cycle, then 8'b10000000 for 3 cycles, then 8'b01000000, and so on.
  - seg=8'hC0 while a digit is selected.
  - frame_done pulses every 32 cycles, first at cycle 31.
- Write 0x89ABCDEF with wr_dp=8'h01 at cycle 5:
  - wr_ready drops at cycle 6.
  - The current frame still shows C0.
  - After the first frame_done, digit7 shows 80, digit6 90, digit5 88, ..., digit0 0E (=8'h0E with dp lit).
  - wr_ready returns to 1.
- Second write offered while pend_flag=1: wr_ready=0, and wr_data is ignored until the boundary. Write presented on the exact boundary cycle: it is applied only at the following boundary.
- en=0 for 7 cycles mid-slot at idx=4, cnt=2:
  - select=0, seg=FF, no frame_done.
  - After re-enable, digit4 continues for the remaining 2 cycles before moving to idx=3.
- digit_mask=8'b11110111: digit3's slot shows select=0 and seg=FF for all 4 cycles. All other digits and the frame period are unchanged.
- rst_n pulsed low at idx=2 with pend_flag=1:
  - Outputs go to reset values asynchronously, and wr_ready=1.
  - Pending data is lost and active_data=0.
  - Scanning restarts at 8'b10000000 after the blank cycle.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit seven-segment scanner with blank interval, hex decode and frame-aligned double-buffered writes
module seg_scan_ctrl #(
  parameter int DWELL = 1000,
  parameter int BLANK = 50
) (
  input  logic        clk_div,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  digit_mask,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  output logic        wr_ready,
  output logic [7:0]  select,
  output logic [7:0]  seg,
  output logic        frame_done
);
  localparam int CW = $clog2(DWELL);
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic [31:0]   active_data, pend_data;
  logic [7:0]    active_dp, pend_dp;
  logic          pend_flag;
  logic          last;
  logic [3:0]    nib;
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction
  always_comb begin
    last       = cnt == CW'(DWELL - 1);
    frame_done = en && idx == 3'd0 && last;
    wr_ready   = ~pend_flag;
    nib        = active_data[idx*4 +: 4];
    select     = (en && cnt >= CW'(BLANK) && digit_mask[idx]) ? 8'(1) << idx : 8'h00;
    seg        = select == 8'h00 ? 8'hFF : {~active_dp[idx], hex7(nib)};
  end
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= 3'd7;
      cnt         <= '0;
      active_data <= '0;
      active_dp   <= '0;
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_flag   <= 1'b0;
    end else begin
      if (en) begin
        cnt <= last ? '0 : cnt + 1'b1;
        idx <= last ? idx - 1'b1 : idx;
      end
      if (frame_done && pend_flag) begin
        active_data <= pend_data;
        active_dp   <= pend_dp;
        pend_flag   <= 1'b0;
      end else if (wr_valid && wr_ready) begin
        pend_data <= wr_data;
        pend_dp   <= wr_dp;
        pend_flag <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench driving directed and random stimulus against a time-based display model
module tb_seg_scan_ctrl;
  localparam int DWELL = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 8 * DWELL;
  typedef struct {
    logic [7:0] sel;
    logic [7:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;
  logic        clk_div;
  logic        rst_n;
  logic        en;
  logic [7:0]  digit_mask;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp;
  logic        wr_ready;
  logic [7:0]  select;
  logic [7:0]  seg;
  logic        frame_done;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  exp_t mx;
  int t;
  logic [31:0] m_act;
  logic [7:0]  m_actdp;
  logic [39:0] m_pend[$];
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  seg_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk_div(clk_div), .rst_n(rst_n), .en(en), .digit_mask(digit_mask),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_dp(wr_dp), .wr_ready(wr_ready),
    .select(select), .seg(seg), .frame_done(frame_done)
  );
  initial begin
    clk_div = 1'b0;
    forever #5 clk_div = ~clk_div;
  end
  // Model: t counts enabled scan cycles since reset; slot, digit and frame position follow arithmetically.
  task automatic step(input logic e, input logic [7:0] m, input logic v,
                      input logic [31:0] d, input logic [7:0] p, input logic r);
    exp_t x;
    int pos, di;
    @(posedge clk_div);
    #1;
    en = e; digit_mask = m; wr_valid = v; wr_data = d; wr_dp = p; rst_n = r;
    if (!r) begin
      t = 0; m_act = 0; m_actdp = 0; m_pend.delete();
    end
    pos = t % DWELL;
    di  = 7 - (t / DWELL) % 8;
    x.sel = (e && pos >= BLANK && m[di]) ? 8'(1 << di) : 8'h00;
    x.seg = x.sel == 8'h00 ? 8'hFF : {~m_actdp[di], hex_tab[m_act[di*4 +: 4]]};
    x.fd  = e && r && (t % FRAME) == FRAME - 1;
    x.rdy = m_pend.size() == 0;
    q.push_back(x);
    if (r) begin
      if (x.fd && m_pend.size() > 0) {m_actdp, m_act} = m_pend.pop_front();
      else if (v && x.rdy) m_pend.push_back({p, d});
      if (e) t++;
    end
  endtask
  task automatic idle();
    step(1'b1, 8'hFF, 1'b0, 32'h0, 8'h0, 1'b1);
  endtask
  always @(negedge clk_div) begin
    if (q.size() > 0) begin
      mx = q.pop_front();
      tests += 4;
      if (select !== mx.sel) begin
        fails++;
        $display("FAIL select @%0t got %b want %b", $time, select, mx.sel);
      end
      if (seg !== mx.seg) begin
        fails++;
        $display("FAIL seg @%0t got %h want %h", $time, seg, mx.seg);
      end
      if (frame_done !== mx.fd) begin
        fails++;
        $display("FAIL frame_done @%0t got %b want %b", $time, frame_done, mx.fd);
      end
      if (wr_ready !== mx.rdy) begin
        fails++;
        $display("FAIL wr_ready @%0t got %b want %b", $time, wr_ready, mx.rdy);
      end
    end
  end
  initial begin
    logic rv, re, rr, acc;
    logic [31:0] rd;
    logic [7:0] rp, rm;
    rst_n = 1'b0; en = 1'b0; digit_mask = 8'hFF; wr_valid = 1'b0; wr_data = '0; wr_dp = '0;
    t = 0; m_act = 0; m_actdp = 0;
    repeat (2) step(1'b1, 8'hFF, 1'b0, 32'h0, 8'h0, 1'b0);
    repeat (5) idle();
    step(1'b1, 8'hFF, 1'b1, 32'h89ABCDEF, 8'h01, 1'b1);
    repeat (70) idle();
    step(1'b1, 8'hFF, 1'b1, 32'h01234567, 8'h80, 1'b1);
    while (m_pend.size() != 0) step(1'b1, 8'hFF, 1'b1, 32'hFEDCBA98, 8'h5A, 1'b1);
    step(1'b1, 8'hFF, 1'b1, 32'hFEDCBA98, 8'h5A, 1'b1);
    repeat (40) idle();
    while (t % FRAME != FRAME - 1) idle();
    step(1'b1, 8'hFF, 1'b1, 32'h13579BDF, 8'hC3, 1'b1);
    repeat (70) idle();
    while (t % FRAME != 14) idle();
    repeat (7) step(1'b0, 8'hFF, 1'b0, 32'h0, 8'h0, 1'b1);
    repeat (20) idle();
    repeat (40) step(1'b1, 8'hF7, 1'b0, 32'h0, 8'h0, 1'b1);
    repeat (40) idle();
    while (t % FRAME != 10) idle();
    step(1'b1, 8'hFF, 1'b1, 32'h2468ACE0, 8'hFF, 1'b1);
    while (t % FRAME != 20) idle();
    repeat (2) step(1'b1, 8'hFF, 1'b0, 32'h0, 8'h0, 1'b0);
    repeat (40) idle();
    rv = 1'b0; rd = '0; rp = '0;
    for (int i = 0; i < 1500; i++) begin
      re = $urandom_range(0, 9) != 0;
      rm = $urandom_range(0, 7) == 0 ? 8'($urandom) : 8'hFF;
      rr = $urandom_range(0, 199) != 0;
      if (!rv) begin
        rv = $urandom_range(0, 2) == 0;
        rd = $urandom;
        rp = 8'($urandom);
      end
      acc = rv && rr && m_pend.size() == 0;
      step(re, rm, rv, rd, rp, rr);
      if (acc) rv = 1'b0;
    end
    repeat (2) @(posedge clk_div);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
